// File: rtl/mips_pkg.sv
// Shared MIPS constants and the IF/ID buffer-state encoding.
package mips_pkg;

    localparam logic [5:0]  OP_J     = 6'h02;
    localparam logic [5:0]  OP_JAL   = 6'h03;
    localparam logic [5:0]  OP_BEQ   = 6'h04;
    localparam logic [5:0]  OP_BNE   = 6'h05;

    // sll $0,$0,0
    localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

    // Encoding matches the buffer occupancy so the state is a direct view of count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } ifid_state_t;

endpackage

// File: rtl/if_id_fetch_buffer_if.sv
// IF->ID handshake bundle; the predecode flags exist only when IFID_PREDECODE_EN is defined.
interface if_id_fetch_buffer_if;

    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        if_ready;
    logic        flush;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        id_ready;
`ifdef IFID_PREDECODE_EN
    logic        id_is_branch;
    logic        id_is_jump;

    modport slave (
        input  if_pc, if_inst, if_valid, flush, id_ready,
        output if_ready, id_pc, id_inst, id_valid, id_is_branch, id_is_jump
    );

    modport master (
        output if_pc, if_inst, if_valid, flush, id_ready,
        input  if_ready, id_pc, id_inst, id_valid, id_is_branch, id_is_jump
    );
`else
    modport slave (
        input  if_pc, if_inst, if_valid, flush, id_ready,
        output if_ready, id_pc, id_inst, id_valid
    );

    modport master (
        output if_pc, if_inst, if_valid, flush, id_ready,
        input  if_ready, id_pc, id_inst, id_valid
    );
`endif

endinterface

// File: rtl/if_id_fetch_buffer_predecoder.sv
// Opcode predecoder for the head instruction; compiled only with IFID_PREDECODE_EN.
`ifdef IFID_PREDECODE_EN
module fetch_predecoder
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic       valid,
    output logic       is_branch,
    output logic       is_jump
);

    // Classify the opcode; an empty buffer presents a bubble, so both flags stay low.
    always_comb begin
        is_branch = 1'b0;
        is_jump   = 1'b0;
        if (valid) begin
            case (opcode)
                OP_BEQ, OP_BNE: is_branch = 1'b1;
                OP_J, OP_JAL:   is_jump   = 1'b1;
                default: begin
                    is_branch = 1'b0;
                    is_jump   = 1'b0;
                end
            endcase
        end else begin
            is_branch = 1'b0;
            is_jump   = 1'b0;
        end
    end

endmodule
`endif

// File: rtl/if_id_fetch_buffer.sv
// 2-entry IF->ID skid buffer with flush; optional head predecode under IFID_PREDECODE_EN.
module if_id_fetch_buffer
    import mips_pkg::*;
#(
    parameter logic [31:0] NOP_INST = MIPS_NOP,
    parameter logic [31:0] EMPTY_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    if_id_fetch_buffer_if.slave   bus
);

    logic [1:0]  count_r;
    logic [1:0]  count_nxt_s;
    logic        rd_ptr_r;
    logic        rd_ptr_nxt_s;
    logic        wr_ptr_r;
    logic        wr_ptr_nxt_s;
    logic        push_s;
    logic        pop_s;
    logic        valid_s;
    logic        ready_s;
    logic [31:0] head_pc_s;
    logic [31:0] head_inst_s;
    ifid_state_t state_s;
    logic [31:0] pc_mem_r   [2];
    logic [31:0] inst_mem_r [2];

    // if_ready depends only on registered occupancy, never on id_ready.
    assign ready_s = (count_r != 2'd2);
    assign valid_s = (count_r != 2'd0);
    assign push_s  = bus.if_valid && ready_s && !bus.flush;
    assign pop_s   = valid_s && bus.id_ready && !bus.flush;

    // View the occupancy count as the buffer state.
    always_comb begin
        state_s = EMPTY;
        case (count_r)
            2'd0:    state_s = EMPTY;
            2'd1:    state_s = ONE;
            2'd2:    state_s = FULL;
            default: state_s = EMPTY;
        endcase
    end

    // Next occupancy and pointers; flush overrides any handshake in the same cycle.
    always_comb begin
        count_nxt_s  = count_r;
        rd_ptr_nxt_s = rd_ptr_r;
        wr_ptr_nxt_s = wr_ptr_r;
        if (bus.flush) begin
            count_nxt_s  = 2'd0;
            rd_ptr_nxt_s = 1'b0;
            wr_ptr_nxt_s = 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_nxt_s = wr_ptr_r + 1'b1;
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_nxt_s = rd_ptr_r + 1'b1;
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            case (state_s)
                EMPTY: count_nxt_s = push_s ? 2'd1 : 2'd0;
                ONE: begin
                    if (push_s && !pop_s) begin
                        count_nxt_s = 2'd2;
                    end else if (pop_s && !push_s) begin
                        count_nxt_s = 2'd0;
                    end else begin
                        count_nxt_s = 2'd1;
                    end
                end
                FULL:    count_nxt_s = pop_s ? 2'd1 : 2'd2;
                default: count_nxt_s = 2'd0;
            endcase
        end
    end

    // Occupancy and pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r  <= 2'd0;
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
        end else begin
            count_r  <= count_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            wr_ptr_r <= wr_ptr_nxt_s;
        end
    end

    // Entry storage is never reset; only occupancy decides what is visible.
    always_ff @(posedge clk) begin
        if (push_s) begin
            pc_mem_r[wr_ptr_r]   <= bus.if_pc;
            inst_mem_r[wr_ptr_r] <= bus.if_inst;
        end
    end

    assign head_pc_s   = valid_s ? pc_mem_r[rd_ptr_r]   : EMPTY_PC;
    assign head_inst_s = valid_s ? inst_mem_r[rd_ptr_r] : NOP_INST;

    assign bus.if_ready = ready_s;
    assign bus.id_valid = valid_s;
    assign bus.id_pc    = head_pc_s;
    assign bus.id_inst  = head_inst_s;

`ifdef IFID_PREDECODE_EN
    fetch_predecoder u_predecoder (
        .opcode    (head_inst_s[31:26]),
        .valid     (valid_s),
        .is_branch (bus.id_is_branch),
        .is_jump   (bus.id_is_jump)
    );
`endif

endmodule

// File: doc/if_id_fetch_buffer.md
# if_id_fetch_buffer

Receiving end of the IF→ID interface: captures each fetched PC/instruction pair from the fetch stage into a 2-entry buffer and presents it to the decode stage under a valid/ready handshake. Back-pressure from decode is returned to fetch as `if_ready`, which drives the program counter's `PCWrite` enable. A flush input discards all buffered entries on a taken branch or jump. When the buffer is empty, decode sees a NOP bubble.

## Interface
- `NOP_INST`, default 32'h0000_0000: instruction word presented while empty (MIPS `sll $0,$0,0`).
- `EMPTY_PC`, default 32'h0000_0000: PC presented while empty.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `if_pc`  in  32  PC of the fetched instruction (`IFtoID_PC`).
- `if_inst`  in  32  fetched instruction word (`IFtoID_inst`).
- `if_valid`  in  1  fetch stage is offering a pair this cycle.
- `if_ready`  out  1  buffer can accept; drives PC `PCWrite`.
- `flush`  in  1  discard all buffered and incoming entries.
- `id_pc`  out  32  PC of the head entry.
- `id_inst`  out  32  instruction of the head entry.
- `id_valid`  out  1  head entry is valid.
- `id_ready`  in  1  decode consumes the head this cycle.
- `id_is_branch`  out  1  head opcode is BEQ/BNE. Present only with `IFID_PREDECODE_EN`.
- `id_is_jump`  out  1  head opcode is J/JAL. Present only with `IFID_PREDECODE_EN`.

## Operation
- Storage is a 2-entry circular buffer holding {pc, inst}.
  - Head pointer `rd_ptr` and tail pointer `wr_ptr` are 1 bit each and wrap modulo 2.
  - Occupancy is a 2-bit `count`.
- State is derived from `count`: EMPTY (0), ONE (1), FULL (2).
- Push occurs when `if_valid && if_ready && !flush`: writes {if_pc, if_inst} at `wr_ptr`, then increments `wr_ptr`.
- Pop occurs when `id_valid && id_ready && !flush`: increments `rd_ptr`.
- `count` update:
  - push only: +1.
  - pop only: −1.
  - push and pop together (only reachable in ONE): unchanged.
- `if_ready = (count != 2)`. This is combinational from registered state and does not depend on `id_ready`; there is no full-buffer pass-through.
- `id_valid = (count != 0)`.
- Output data:
  - When `id_valid`: `id_pc`/`id_inst` show the entry at `rd_ptr`.
  - When empty: they show `EMPTY_PC`/`NOP_INST`.
- `flush` has priority over everything:
  - Next cycle: `count=0` and `rd_ptr=wr_ptr=0`.
  - A push and a pop in the same cycle are both ignored.
- Writes to entry storage when empty are harmless; storage contents are never reset.
- State transitions:
  - EMPTY→ONE on push.
  - ONE→FULL on push without pop.
  - ONE→EMPTY on pop without push.
  - FULL→ONE on pop.
  - Any state→EMPTY on flush.

## Timing
- Reset (async assert, released synchronously to `clk`):
  - `count=0`, pointers 0.
  - Therefore `id_valid=0`, `if_ready=1`, `id_pc=EMPTY_PC`, `id_inst=NOP_INST`, predecode flags 0.
- Latency: a pair pushed at edge N is visible on `id_*` after edge N (one cycle). There is no combinational if→id path.
- Throughput: one push and one pop per cycle in steady state (ONE with both handshakes active).
- `if_ready` drops in the cycle after the second unpopped push. The PC must hold while `if_ready=0`.
- `rst` asserted mid-operation discards contents immediately (asynchronous). Outputs return to their reset values without waiting for a clock edge.

## Configuration
- `IFID_PREDECODE_EN` defined:
  - `id_is_branch`/`id_is_jump` ports exist.
  - They decode `id_inst[31:26]` of the head: BEQ 6'h04, BNE 6'h05, J 6'h02, JAL 6'h03.
  - Both are forced to 0 when `id_valid=0`.
- Not defined: both ports are removed and no decode logic is synthesized. All other behaviour is identical.

## Structure
- Shared package `mips_pkg`:
  - Opcode constants `OP_BEQ`, `OP_BNE`, `OP_J`, `OP_JAL`.
  - `MIPS_NOP` constant.
  - Buffer-state enum `ifid_state_t` {EMPTY, ONE, FULL}.
- One sub-module: `fetch_predecoder` (combinational opcode → branch/jump flags), instantiated only under `IFID_PREDECODE_EN`.

## Test plan
- Reset, then idle:
  - Required: `id_valid=0`, `if_ready=1`, `id_inst=32'h0`, `id_pc=32'h0`.
  - Assert `rst` mid-FULL: all of these return to the same values immediately, without a clock edge.
- Push {0x0, 0x2008_0005} with `id_ready=1` held:
  - Required: `id_valid=1`, `id_pc=0x0`, `id_inst=0x2008_0005` exactly one cycle later.
  - Streaming 0x0, 0x4, 0x8 back-to-back yields one entry per cycle, in order.
- Hold `id_ready=0` and push 0x0, 0x4:
  - Required: `if_ready=0` after the second push, while `id_pc` stays 0x0.
  - Releasing `id_ready` for two cycles drains 0x0 then 0x4, then `id_valid=0`.
- Wrap-around: 6 pushes (0x0..0x14) with `id_ready` toggling every cycle.
  - Required: the output order is exactly 0x0, 0x4, … 0x14, with no loss or duplication.
- `flush` while FULL, coincident with `if_valid=1` (pc 0x40) and `id_ready=1`:
  - Required next cycle: `id_valid=0`, `if_ready=1`.
  - 0x40 is never presented.
  - A following push of 0x80 appears one cycle later.
- With `IFID_PREDECODE_EN`: push 0x1000_0003 (BEQ), then 0x0800_0010 (J).
  - Required: `id_is_branch=1`/`id_is_jump=0` for the first, `0`/`1` for the second.
  - Both flags are 0 when empty.
